fetch_sequencer: RTL and testbench

//  Program-counter and instruction-fetch controller for the WDPM core. Drives the program memory

---
 rtl/wdpm_pkg.sv | 46 ++++
 rtl/instr_field_decode.sv | 26 ++
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdpm_pkg.sv
// Shared encodings for the WDPM core: opcodes, register codes, fetch FSM states
// and the instruction field layout.
package wdpm_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_LD  = 4'b1000,
    OP_ST  = 4'b1001,
    OP_NOP = 4'b1010,
    OP_MOV = 4'b1011,
    OP_CMP = 4'b1100,
    OP_INC = 4'b1101,
    OP_DEC = 4'b1110,
    OP_JMP = 4'b1111
  } opcode_e;

  localparam logic [3:0] REG_R0  = 4'h0;
  localparam logic [3:0] REG_R1  = 4'h1;
  localparam logic [3:0] REG_R2  = 4'h2;
  localparam logic [3:0] REG_R3  = 4'h3;
  localparam logic [3:0] REG_ID  = 4'h4;
  localparam logic [3:0] REG_DM0 = 4'h5;
  localparam logic [3:0] REG_DM1 = 4'h6;
  localparam logic [3:0] REG_DM2 = 4'h7;
  localparam logic [3:0] REG_DM3 = 4'h8;

  // Fetch FSM encoding; WAIT_STEP is only reachable in single-step builds.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;
  localparam logic [2:0] ST_WAIT_STEP = 3'd5;

  localparam int OPCODE_BITS  = 4;
  localparam int REGCODE_BITS = 4;
  localparam int JMP_TGT_MSB  = 7;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field decode of the instruction register: NOP/JMP detection
// and extraction of the jump target from the upper bits of the value field.
module instr_field_decode
  import wdpm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] ir,
  output logic                  is_nop,
  output logic                  is_jmp,
  output logic [ADDR_WIDTH-1:0] jmp_target
);

  logic [OPCODE_BITS-1:0] opcode_s;
  logic                   unused_fields_s;

  assign opcode_s   = ir[DATA_WIDTH-1 -: OPCODE_BITS];
  assign is_nop     = (opcode_s == OP_NOP);
  assign is_jmp     = (opcode_s == OP_JMP);
  // Target is left-aligned at bit 7; the reserved low bits are ignored.
  assign jmp_target = ir[JMP_TGT_MSB -: ADDR_WIDTH];

  assign unused_fields_s = ^ir[DATA_WIDTH-OPCODE_BITS-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// PC / instruction-fetch controller of the WDPM core. Optional single-step
// mode (STEP port, WAIT_STEP state) is enabled by defining SINGLE_STEP_EN.
module fetch_sequencer
  import wdpm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RUN,
  output logic [ADDR_WIDTH-1:0] PM_ADDR,
  input  logic [DATA_WIDTH-1:0] PM_DATA,
  output logic [DATA_WIDTH-1:0] IR_OUT,
  output logic                  IR_VALID,
  input  logic                  EX_READY,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic [CNT_WIDTH-1:0]  RETIRED,
  output logic                  HALTED
`ifdef SINGLE_STEP_EN
  ,
  input  logic                  STEP
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] ir_q,       ir_d;
  logic [CNT_WIDTH-1:0]  retired_q,  retired_d;
  logic                  halted_q,   halted_d;
  logic                  ir_valid_q, ir_valid_d;

  logic                  is_nop_s;
  logic                  is_jmp_s;
  logic [ADDR_WIDTH-1:0] jmp_target_s;

  instr_field_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .ir        (ir_q),
    .is_nop    (is_nop_s),
    .is_jmp    (is_jmp_s),
    .jmp_target(jmp_target_s)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (RUN) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (!RUN) begin
          state_d = ST_IDLE;
        end else begin
          ir_d    = PM_DATA;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // A jump onto itself can never make progress, so it parks the core.
        if (is_jmp_s) begin
          if (jmp_target_s == pc_q) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            pc_d    = jmp_target_s;
            state_d = ST_FETCH;
          end
        end else if (is_nop_s) begin
          pc_d    = pc_q + PC_ONE;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (EX_READY) begin
          pc_d      = pc_q + PC_ONE;
          retired_d = retired_q + CNT_ONE;
`ifdef SINGLE_STEP_EN
          state_d   = ST_WAIT_STEP;
`else
          state_d   = ST_FETCH;
`endif
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
`ifdef SINGLE_STEP_EN
      ST_WAIT_STEP: begin
        if (!RUN)      state_d = ST_IDLE;
        else if (STEP) state_d = ST_FETCH;
        else           state_d = ST_WAIT_STEP;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ir_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      retired_q  <= retired_d;
      halted_q   <= halted_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign PM_ADDR  = pc_q;
  assign PC_OUT   = pc_q;
  assign IR_OUT   = ir_q;
  assign IR_VALID = ir_valid_q;
  assign RETIRED  = retired_q;
  assign HALTED   = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {IR, PC} pairs are queued by the
// stimulus and popped by a monitor at every IR_VALID/EX_READY handshake.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [4:0]  pm_addr;
  logic [15:0] pm_data;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ex_ready;
  logic [4:0]  pc_out;
  logic [15:0] retired;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif

  logic [15:0] pm [0:31];
  logic [20:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .CLK     (clk),
    .RST     (rst),
    .RUN     (run),
    .PM_ADDR (pm_addr),
    .PM_DATA (pm_data),
    .IR_OUT  (ir_out),
    .IR_VALID(ir_valid),
    .EX_READY(ex_ready),
    .PC_OUT  (pc_out),
    .RETIRED (retired),
    .HALTED  (halted)
`ifdef SINGLE_STEP_EN
    ,
    .STEP    (step)
`endif
  );

  assign pm_data = pm[pm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [20:0] e;
    if (!rst && ir_valid && ex_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got ir=%h pc=%0d, required no issue", ir_out, pc_out);
      end else begin
        e = exp_q.pop_front();
        if ({ir_out, pc_out} !== e) begin
          errors++;
          $display("FAIL issue_data: got ir=%h pc=%0d, required ir=%h pc=%0d",
                   ir_out, pc_out, e[20:5], e[4:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every location defaults to a self-jump so a finished program halts.
  task automatic load_default();
    for (int i = 0; i < 32; i++) begin
      logic [4:0] a;
      a = 5'(i);
      pm[i] = {4'hF, 4'h0, a, 3'b000};
    end
  endtask

  task automatic do_reset();
    run      = 1'b0;
    ex_ready = 1'b1;
`ifdef SINGLE_STEP_EN
    step     = 1'b0;
`endif
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    load_default();
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!ir_valid && n < 20);
    if (!ir_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no IR_VALID in %0d cycles, required IR_VALID", name, n);
    end
  endtask

  initial begin
    int          n;
    int          vcount;
    logic [15:0] snap;
    rst = 1'b1;
    run = 1'b0;
    ex_ready = 1'b1;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    load_default();
    #1;

    // Reset values
    do_reset();
    chk("rst_valid",   32'(ir_valid), 32'd0);
    chk("rst_pc",      32'(pc_out),   32'd0);
    chk("rst_pm_addr", 32'(pm_addr),  32'd0);
    chk("rst_ir",      32'(ir_out),   32'd0);
    chk("rst_retired", 32'(retired),  32'd0);
    chk("rst_halted",  32'(halted),   32'd0);

    // 1: ADD, SUB, OR back to back
    pm[0] = 16'h0105; pm[1] = 16'h1203; pm[2] = 16'h3302;
    exp_q.push_back({16'h0105, 5'd0});
    exp_q.push_back({16'h1203, 5'd1});
    exp_q.push_back({16'h3302, 5'd2});
    run = 1'b1;
    wait_valid("t1_first", n);
    chk("t1_first_latency", 32'(n), 32'd3);
    cyc(20);
    chk("t1_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t1_retired",    32'(retired),      32'd3);
    chk("t1_pc",         32'(pc_out),       32'd3);
    chk("t1_halted",     32'(halted),       32'd1);

    // 2: NOP skipped, ADD issued from address 1
    do_reset();
    pm[0] = 16'hA000; pm[1] = 16'h0105;
    exp_q.push_back({16'h0105, 5'd1});
    run = 1'b1;
    cyc(20);
    chk("t2_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t2_retired",    32'(retired),      32'd1);
    chk("t2_pc",         32'(pc_out),       32'd2);

    // 3: JMP 20 then AND
    do_reset();
    pm[0] = 16'hF0A0; pm[20] = 16'h2111;
    exp_q.push_back({16'h2111, 5'd20});
    run = 1'b1;
    cyc(3);
    chk("t3_pc_after_jmp", 32'(pc_out), 32'd20);
    cyc(20);
    chk("t3_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t3_retired",    32'(retired),      32'd1);
    chk("t3_pc",         32'(pc_out),       32'd21);

    // 4: JMP 5, then self-jump at 5 halts
    do_reset();
    pm[0] = 16'hF028;
    run = 1'b1;
    cyc(10);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_pc",     32'(pc_out), 32'd5);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (ir_valid) vcount++;
    end
    chk("t4_valid_in_halt", 32'(vcount),  32'd0);
    chk("t4_retired",       32'(retired), 32'd0);
    do_reset();
    chk("t4_halted_cleared", 32'(halted), 32'd0);
    chk("t4_pc_cleared",     32'(pc_out), 32'd0);

    // 5: stall in ISSUE with RUN dropped, then PC wrap from 31
    do_reset();
    pm[0] = 16'h0105; pm[1] = 16'hF0F8; pm[31] = 16'h0407;
    ex_ready = 1'b0;
    run = 1'b1;
    wait_valid("t5_first", n);
    exp_q.push_back({16'h0105, 5'd0});
    snap = ir_out;
    chk("t5_ir_captured", 32'(snap), 32'h0105);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("t5_stall_valid", 32'(ir_valid), 32'd1);
      chk("t5_stall_ir",    32'(ir_out),   32'(snap));
    end
    ex_ready = 1'b1;
    cyc(1);
    cyc(5);
    chk("t5_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t5_idle_valid", 32'(ir_valid),     32'd0);
    chk("t5_pc",         32'(pc_out),       32'd1);
    chk("t5_retired",    32'(retired),      32'd1);
    chk("t5_halted",     32'(halted),       32'd0);
    pm[0] = 16'hF000;
    exp_q.push_back({16'h0407, 5'd31});
    run = 1'b1;
    cyc(20);
    chk("t5_wrap_queue", 32'(exp_q.size()), 32'd0);
    chk("t5_wrap_pc",    32'(pc_out),       32'd0);
    chk("t5_wrap_halt",  32'(halted),       32'd1);
    chk("t5_wrap_ret",   32'(retired),      32'd2);

    // 7: asynchronous reset in the middle of ISSUE
    do_reset();
    pm[0] = 16'h0105;
    ex_ready = 1'b0;
    run = 1'b1;
    wait_valid("t7_first", n);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_valid",   32'(ir_valid), 32'd0);
    chk("t7_async_retired", 32'(retired),  32'd0);
    chk("t7_async_pc",      32'(pc_out),   32'd0);
    cyc(1);
    rst = 1'b0;

`ifdef SINGLE_STEP_EN
    // 6: single step stalls after each issued instruction
    do_reset();
    pm[0] = 16'h0105; pm[1] = 16'h1203;
    exp_q.push_back({16'h0105, 5'd0});
    exp_q.push_back({16'h1203, 5'd1});
    run = 1'b1;
    cyc(15);
    chk("t6_pending", 32'(exp_q.size()), 32'd1);
    chk("t6_ret1",    32'(retired),      32'd1);
    chk("t6_pc1",     32'(pc_out),       32'd1);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(10);
    chk("t6_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t6_ret2",       32'(retired),      32'd2);
    chk("t6_pc2",        32'(pc_out),       32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
